// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative-latency HI/LO multiply/divide unit for a MIPS-style pipeline.
//   MULT/MULTU take 5 cycles and DIV/DIVU take 10 cycles, with busy high for
//   the whole run. MTHI/MTLO write HI/LO in zero cycles. Results are computed
//   from the operands latched when the request is accepted, and HI/LO are
//   written only at the completing edge.
//
//   Optional feature: define MDU_DIV_EN to build the divider. Without it,
//   DIV/DIVU are treated as no-ops and no divider logic exists.
//
// Ports
//   clk      in   clock, rising edge
//   reset_n  in   async active-low reset
//   start    in   request strobe (ignored while busy)
//   MDopE    in   [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 nop
//   SrcAE    in   [31:0] operand A / MT* data
//   SrcBE    in   [31:0] operand B
//   HIsel    in   MDoutE read select (1 = HI, 0 = LO)
//   busy     out  operation in flight
//   HI, LO   out  [31:0] architectural registers
//   MDoutE   out  [31:0] HIsel ? HI : LO
module mult_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  MDopE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        HIsel,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDoutE
);
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        is_mul, is_div;
    logic [63:0] prod;

    assign is_mul = (MDopE == OP_MULT) || (MDopE == OP_MULTU);

    // One 64x64 multiplier serves both flavours: operands are sign- or
    // zero-extended per the latched signedness, low 64 bits are the product.
    assign prod = {{32{sgn_q & a_q[31]}}, a_q} * {{32{sgn_q & b_q[31]}}, b_q};

`ifdef MDU_DIV_EN
    logic        div_q, div_d;
    logic [31:0] abs_a, abs_b, den, uq, ur, quo, rem;

    assign is_div = (MDopE == OP_DIV) || (MDopE == OP_DIVU);

    // Magnitude divide then fix signs: quotient truncates toward zero and the
    // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000
    // because the negated magnitude wraps back to itself.
    assign abs_a = (sgn_q && a_q[31]) ? (32'd0 - a_q) : a_q;
    assign abs_b = (sgn_q && b_q[31]) ? (32'd0 - b_q) : b_q;
    assign den   = (b_q == 32'd0) ? 32'd1 : abs_b;  // result discarded on /0
    assign uq    = abs_a / den;
    assign ur    = abs_a % den;
    assign quo   = (sgn_q && (a_q[31] ^ b_q[31])) ? (32'd0 - uq) : uq;
    assign rem   = (sgn_q && a_q[31]) ? (32'd0 - ur) : ur;
`else
    assign is_div = 1'b0;
`endif

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
`ifdef MDU_DIV_EN
            div_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
`ifdef MDU_DIV_EN
            div_q   <= div_d;
`endif
        end
    end

    // Next-state and HI/LO update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
`ifdef MDU_DIV_EN
        div_d   = div_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_mul || is_div) begin
                        state_d = RUN;
                        cnt_d   = is_div ? 4'd9 : 4'd4;
                        a_d     = SrcAE;
                        b_d     = SrcBE;
                        sgn_d   = (MDopE == OP_MULT) || (MDopE == OP_DIV);
`ifdef MDU_DIV_EN
                        div_d   = is_div;
`endif
                    end else if (MDopE == OP_MTHI) begin
                        hi_d = SrcAE;
                    end else if (MDopE == OP_MTLO) begin
                        lo_d = SrcAE;
                    end
                end
            end
            RUN: begin
                // A start arriving at the completing edge still sees RUN and
                // is dropped.
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
`ifdef MDU_DIV_EN
                    if (div_q) begin
                        if (b_q != 32'd0) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end else begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end
`else
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
`endif
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy   = (state_q == RUN);
        HI     = hi_q;
        LO     = lo_q;
        MDoutE = HIsel ? hi_q : lo_q;
    end

endmodule
